// File: rtl/sensor_display_scanner.sv
// Multi-channel sensor word capture with a multiplexed active-low hex 7-seg display.
// Optional stale-data marking is enabled by defining SENSOR_DISP_STALE_EN.
module sensor_display_scanner #(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 24,
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV      = 100000,
    parameter int ROTATE_CYCLES = 200000000,
    parameter int STALE_CYCLES  = 50000000
) (
    input  logic                                        CLK100MHZ,
    input  logic                                        reset,
    input  logic [NUM_CH*DATA_W-1:0]                    ch_data,
    input  logic [NUM_CH-1:0]                           ch_valid,
    input  logic                                        btn_next,
    output logic [6:0]                                  seg,
    output logic                                        dp,
    output logic [NUM_DIGITS-1:0]                       an,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HEX_N = (DATA_W + 3) / 4;
    localparam int PAD_W = HEX_N * 4;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ROT_W = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    logic [DATA_W-1:0] r_shadow [NUM_CH];
    logic [DATA_W-1:0] r_frame;
    logic [CH_W-1:0]   r_fch;
    logic [CH_W-1:0]   r_cur;
    logic [DIV_W-1:0]  r_div;
    logic [DIG_W-1:0]  r_dig;
    logic              r_btn_s1, r_btn_s2, r_btn_d;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [NUM_DIGITS-1:0] r_an;

    logic              w_btn_rise;
    logic              w_rot_wrap;
    logic              w_div_wrap;
    logic              w_frame_start;
    logic              w_stale;
    logic [PAD_W-1:0]  w_frame_pad;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg_nx;
    logic              w_dp_nx;
    logic [NUM_DIGITS-1:0] w_an_nx;

    assign w_btn_rise    = r_btn_s2 & ~r_btn_d;
    assign w_div_wrap    = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_frame_start = w_div_wrap && (r_dig == DIG_W'(NUM_DIGITS - 1));

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++)
                if (ch_valid[k]) r_shadow[k] <= ch_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_btn_d  <= 1'b0;
        end else begin
            r_btn_s1 <= btn_next;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
        end
    end

    // A button edge also restarts the rotate interval so the new channel gets a full dwell.
    generate
        if (ROTATE_CYCLES != 0) begin : g_rot
            logic [ROT_W-1:0] r_rot;
            assign w_rot_wrap = (r_rot == ROT_W'(ROTATE_CYCLES - 1));
            always_ff @(posedge CLK100MHZ or posedge reset) begin
                if (reset)
                    r_rot <= '0;
                else if (w_btn_rise || w_rot_wrap)
                    r_rot <= '0;
                else
                    r_rot <= r_rot + 1'b1;
            end
        end else begin : g_norot
            assign w_rot_wrap = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            r_cur <= '0;
        else if (w_btn_rise || w_rot_wrap)
            r_cur <= (r_cur == CH_W'(NUM_CH - 1)) ? '0 : r_cur + 1'b1;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_dig   <= '0;
            r_frame <= '0;
            r_fch   <= '0;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + 1'b1;
            if (w_div_wrap)
                r_dig <= (r_dig == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_dig + 1'b1;
            if (w_frame_start) begin
                r_frame <= r_shadow[r_cur];
                r_fch   <= r_cur;
            end
        end
    end

`ifdef SENSOR_DISP_STALE_EN
    localparam int AGE_W = $clog2(STALE_CYCLES + 1);
    logic [AGE_W-1:0] r_age [NUM_CH];
    logic             r_stale;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) r_age[k] <= '0;
            r_stale <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid[k])
                    r_age[k] <= '0;
                else if (r_age[k] != AGE_W'(STALE_CYCLES))
                    r_age[k] <= r_age[k] + 1'b1;
            end
            if (w_frame_start)
                r_stale <= (r_age[r_cur] == AGE_W'(STALE_CYCLES));
        end
    end
    assign w_stale = r_stale;
`else
    assign w_stale = 1'b0;
`endif

    assign w_frame_pad = PAD_W'(r_frame);
    assign w_nib       = 4'(w_frame_pad >> {r_dig, 2'b00});

    always_comb begin
        w_an_nx        = '1;
        w_an_nx[r_dig] = 1'b0;
        w_seg_nx       = 7'h7F;
        w_dp_nx        = 1'b1;
        if (r_dig < DIG_W'(HEX_N)) begin
            w_seg_nx = w_stale ? 7'h3F : hex7(w_nib);
        end else if (r_dig == DIG_W'(NUM_DIGITS - 1)) begin
            w_seg_nx = hex7(4'(r_fch));
            w_dp_nx  = 1'b0;
        end
    end

    // Anode, segment and dp registers share one edge so no ghosting between digits.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_nx;
            r_dp  <= w_dp_nx;
            r_an  <= w_an_nx;
        end
    end

    assign seg    = r_seg;
    assign dp     = r_dp;
    assign an     = r_an;
    assign cur_ch = r_cur;

endmodule

// File: tb/tb_sensor_display_scanner.sv
// Directed bench for sensor_display_scanner: scan frames, capture, button, rotate, reset,
// and (with SENSOR_DISP_STALE_EN) stale marking.
module tb_sensor_display_scanner;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_r;
    logic [71:0] ch_data;
    logic [2:0]  ch_valid;
    logic        btn, btn_r;

    logic [6:0]  seg_m, seg_r, seg_s;
    logic        dp_m, dp_r, dp_s;
    logic [7:0]  an_m, an_r, an_s;
    logic [1:0]  cur_m, cur_r;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_cyc  = 0;

    sensor_display_scanner #(
        .NUM_CH(3), .DATA_W(24), .NUM_DIGITS(8), .SCAN_DIV(4),
        .ROTATE_CYCLES(0), .STALE_CYCLES(1000000)
    ) dut_m (
        .CLK100MHZ(clk), .reset(rst), .ch_data(ch_data), .ch_valid(ch_valid),
        .btn_next(btn), .seg(seg_m), .dp(dp_m), .an(an_m), .cur_ch(cur_m)
    );

    sensor_display_scanner #(
        .NUM_CH(3), .DATA_W(24), .NUM_DIGITS(8), .SCAN_DIV(4),
        .ROTATE_CYCLES(64), .STALE_CYCLES(1000000)
    ) dut_r (
        .CLK100MHZ(clk), .reset(rst_r), .ch_data(ch_data), .ch_valid(ch_valid),
        .btn_next(btn_r), .seg(seg_r), .dp(dp_r), .an(an_r), .cur_ch(cur_r)
    );

`ifdef SENSOR_DISP_STALE_EN
    logic [1:0] cur_s;
    sensor_display_scanner #(
        .NUM_CH(3), .DATA_W(24), .NUM_DIGITS(8), .SCAN_DIV(4),
        .ROTATE_CYCLES(0), .STALE_CYCLES(200)
    ) dut_s (
        .CLK100MHZ(clk), .reset(rst_r), .ch_data(ch_data), .ch_valid(ch_valid),
        .btn_next(btn_r), .seg(seg_s), .dp(dp_s), .an(an_s), .cur_ch(cur_s)
    );
`else
    assign seg_s = 7'h7F;
    assign dp_s  = 1'b1;
    assign an_s  = 8'hFF;
`endif

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int ch, input logic [23:0] word);
        ch_data[ch*24 +: 24] = word;
        ch_valid             = 3'b001 << ch;
        @(negedge clk);
        ch_valid             = 3'b000;
    endtask

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            n_cyc++;
        end
    endtask

    // Returns at the first sample where the selected display enters digit 0.
    task automatic wait_fs(input bit st);
        logic [7:0] prev;
        bit         found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            prev = st ? an_s : an_m;
            @(negedge clk);
            if ((st ? an_s : an_m) == 8'hFE && prev != 8'hFE) found = 1'b1;
        end
        check("frame_start_seen", 32'(found), 32'd1);
    endtask

    task automatic check_frame(input bit st, input logic [23:0] word, input logic [3:0] ch,
                               input bit stale, input bit inject, input logic [23:0] nword);
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (inject && d == 3 && c == 0) begin
                    ch_data[23:0] = nword;
                    ch_valid      = 3'b001;
                end else begin
                    ch_valid      = 3'b000;
                end
                e_an  = ~(8'h01 << d);
                e_dp  = 1'b1;
                e_seg = 7'h7F;
                if (d < 6)
                    e_seg = stale ? 7'h3F : font(4'(word >> (4 * d)));
                else if (d == 7) begin
                    e_seg = font(ch);
                    e_dp  = 1'b0;
                end
                check($sformatf("an_d%0d_c%0d", d, c),  32'(st ? an_s : an_m),   32'(e_an));
                check($sformatf("seg_d%0d_c%0d", d, c), 32'(st ? seg_s : seg_m), 32'(e_seg));
                check($sformatf("dp_d%0d_c%0d", d, c),  32'(st ? dp_s : dp_m),   32'(e_dp));
                @(negedge clk);
            end
        end
        ch_valid = 3'b000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_r = 1'b1; btn = 1'b0; btn_r = 1'b0;
        ch_data = '0; ch_valid = '0;
        @(negedge clk); @(negedge clk);

        check("rst_seg", 32'(seg_m), 32'h7F);
        check("rst_dp",  32'(dp_m),  32'h1);
        check("rst_an",  32'(an_m),  32'hFF);
        check("rst_cur", 32'(cur_m), 32'h0);
        check("rot_rst_an",  32'(an_r),  32'hFF);
        check("rot_rst_seg", 32'(seg_r), 32'h7F);
        check("rot_rst_dp",  32'(dp_r),  32'h1);
        rst = 1'b0;

        // Channel 0 word shown with channel digit 0.
        strobe(0, 24'h12AB9F);
        wait_fs(0); wait_fs(0);
        check_frame(0, 24'h12AB9F, 4'd0, 1'b0, 1'b0, 24'h0);

        // Button advances to channel 1 three cycles after its edge.
        strobe(1, 24'h00C0DE);
        btn = 1'b1;
        @(negedge clk); @(negedge clk);
        check("btn_cur_2cyc", 32'(cur_m), 32'd0);
        @(negedge clk);
        check("btn_cur_3cyc", 32'(cur_m), 32'd1);
        btn = 1'b0;
        wait_fs(0); wait_fs(0);
        check_frame(0, 24'h00C0DE, 4'd1, 1'b0, 1'b0, 24'h0);

        // Asynchronous reset in the middle of a scan.
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("pre_rst_lit", 32'(an_m != 8'hFF), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_seg", 32'(seg_m), 32'h7F);
        check("mid_rst_dp",  32'(dp_m),  32'h1);
        check("mid_rst_an",  32'(an_m),  32'hFF);
        check("mid_rst_cur", 32'(cur_m), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_fs(0);
        check_frame(0, 24'h000000, 4'd0, 1'b0, 1'b0, 24'h0);
        check_frame(0, 24'h000000, 4'd0, 1'b0, 1'b0, 24'h0);

        // Mid-frame update never tears the frame; new word appears next frame.
        strobe(0, 24'h12AB9F);
        wait_fs(0); wait_fs(0);
        check_frame(0, 24'h12AB9F, 4'd0, 1'b0, 1'b1, 24'h345678);
        check_frame(0, 24'h345678, 4'd0, 1'b0, 1'b0, 24'h0);

        // Auto-rotate every 64 cycles; coincident button edge steps once; button restarts interval.
        rst_r = 1'b0;
        n_cyc = 0;
        tick(63);  check("rot_63",  32'(cur_r), 32'd0);
        tick(1);   check("rot_64",  32'(cur_r), 32'd1);
        tick(61);  btn_r = 1'b1;
        tick(2);   check("rot_127", 32'(cur_r), 32'd1);
        tick(1);   check("rot_128_btn", 32'(cur_r), 32'd2);
        tick(12);  btn_r = 1'b0;
        tick(51);  check("rot_191", 32'(cur_r), 32'd2);
        tick(1);   check("rot_192", 32'(cur_r), 32'd0);
        tick(15);  btn_r = 1'b1;
        tick(2);   check("rot_209", 32'(cur_r), 32'd0);
        tick(1);   check("rot_210_btn", 32'(cur_r), 32'd1);
        tick(10);  btn_r = 1'b0;
        tick(36);  check("rot_256_cleared", 32'(cur_r), 32'd1);
        tick(17);  check("rot_273", 32'(cur_r), 32'd1);
        tick(1);   check("rot_274", 32'(cur_r), 32'd2);
        check("rot_cycle_count", 32'(n_cyc), 32'd274);

`ifdef SENSOR_DISP_STALE_EN
        rst_r = 1'b1;
        @(negedge clk);
        check("stale_rst_cur", 32'(cur_s), 32'd0);
        rst_r = 1'b0;
        strobe(0, 24'h12AB9F);
        tick(300);
        wait_fs(1); wait_fs(1);
        check_frame(1, 24'h12AB9F, 4'd0, 1'b1, 1'b0, 24'h0);
        strobe(0, 24'h12AB9F);
        wait_fs(1); wait_fs(1);
        check_frame(1, 24'h12AB9F, 4'd0, 1'b0, 1'b0, 24'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
